mips_instr_decoder: RTL

- Pipelined decode stage: the receive-side counterpart of the instruction encoding helpers.
- Accepts 32-bit MIPS words from fetch over a valid/ready handshake.
- Splits each word into fields, builds the extended immediate and derives control signals for execute.
- Holds results in a registered output with a 2-entry skid buffer, so upstream never sees combinational ready from downstream. Flags and counts unsupported encodings.

---
 rtl/mips_instr_decoder.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_instr_decoder.sv
// MIPS decode stage: splits fetch words into fields and control for execute, behind a registered output plus skid slot.
// Optional: define DECODE_SEQ_EN to decode R-format funct 0x2E as seq; otherwise it is reported illegal.
module mips_instr_decoder #(
    parameter int          ILL_CNT_W = 8,
    parameter logic [31:0] RESET_NOP = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [4:0]           out_rs,
    output logic [4:0]           out_rt,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_shamt,
    output logic [31:0]          out_imm,
    output logic [4:0]           out_alu_op,
    output logic [4:0]           out_dest,
    output logic                 out_reg_write,
    output logic                 out_mem_read,
    output logic                 out_mem_write,
    output logic                 out_hilo_write,
    output logic                 out_syscall,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,  ALU_SUB  = 5'd1,  ALU_AND  = 5'd2,  ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,  ALU_NOR  = 5'd5,  ALU_SLT  = 5'd6,  ALU_SLTU  = 5'd7,
        ALU_SLL   = 5'd8,  ALU_SRL  = 5'd9,  ALU_SRA  = 5'd10, ALU_LUI   = 5'd11,
        ALU_MFHI  = 5'd12, ALU_MFLO = 5'd13, ALU_MTHI = 5'd14, ALU_MTLO  = 5'd15,
        ALU_MULT  = 5'd16, ALU_MULTU = 5'd17, ALU_DIV = 5'd18, ALU_DIVU  = 5'd19,
        ALU_SEQ   = 5'd20, ALU_NONE = 5'd31
    } alu_op_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        hilo_write;
        logic        syscall;
        logic        illegal;
    } bundle_t;

    localparam bundle_t C_RESET_BUNDLE = '{instr: RESET_NOP, alu_op: ALU_ADD, default: '0};

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [15:0] w_imm16;
    alu_op_e     w_alu_op;
    logic        w_legal;
    logic        w_gpr;
    logic [31:0] w_imm;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_hilo;
    logic        w_sys;
    logic [4:0]  w_dest;
    bundle_t     w_dec;
    logic        w_accept;
    logic        w_consume;

    bundle_t               r_out;
    logic                  r_out_valid;
    bundle_t               r_skid;
    logic                  r_skid_valid;
    logic                  r_in_ready;
    logic [ILL_CNT_W-1:0]  r_ill_count;

    assign w_opcode = in_instr[31:26];
    assign w_funct  = in_instr[5:0];
    assign w_imm16  = in_instr[15:0];

    always_comb begin
        w_alu_op    = ALU_NONE;
        w_legal     = 1'b1;
        w_gpr       = 1'b0;
        w_imm       = 32'h0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_hilo      = 1'b0;
        w_sys       = 1'b0;
        if (w_opcode == 6'h00) begin
            case (w_funct)
                6'h21: begin w_alu_op = ALU_ADD;   w_gpr  = 1'b1; end
                6'h23: begin w_alu_op = ALU_SUB;   w_gpr  = 1'b1; end
                6'h24: begin w_alu_op = ALU_AND;   w_gpr  = 1'b1; end
                6'h25: begin w_alu_op = ALU_OR;    w_gpr  = 1'b1; end
                6'h26: begin w_alu_op = ALU_XOR;   w_gpr  = 1'b1; end
                6'h27: begin w_alu_op = ALU_NOR;   w_gpr  = 1'b1; end
                6'h2A: begin w_alu_op = ALU_SLT;   w_gpr  = 1'b1; end
                6'h2B: begin w_alu_op = ALU_SLTU;  w_gpr  = 1'b1; end
                6'h00, 6'h04: begin w_alu_op = ALU_SLL; w_gpr = 1'b1; end
                6'h02, 6'h06: begin w_alu_op = ALU_SRL; w_gpr = 1'b1; end
                6'h03, 6'h07: begin w_alu_op = ALU_SRA; w_gpr = 1'b1; end
                6'h10: begin w_alu_op = ALU_MFHI;  w_gpr  = 1'b1; end
                6'h12: begin w_alu_op = ALU_MFLO;  w_gpr  = 1'b1; end
                6'h11: begin w_alu_op = ALU_MTHI;  w_hilo = 1'b1; end
                6'h13: begin w_alu_op = ALU_MTLO;  w_hilo = 1'b1; end
                6'h18: begin w_alu_op = ALU_MULT;  w_hilo = 1'b1; end
                6'h19: begin w_alu_op = ALU_MULTU; w_hilo = 1'b1; end
                6'h1A: begin w_alu_op = ALU_DIV;   w_hilo = 1'b1; end
                6'h1B: begin w_alu_op = ALU_DIVU;  w_hilo = 1'b1; end
                6'h0C: begin w_alu_op = ALU_ADD;   w_sys  = 1'b1; end
`ifdef DECODE_SEQ_EN
                6'h2E: begin w_alu_op = ALU_SEQ;   w_gpr  = 1'b1; end
`endif
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (w_opcode)
                6'h09: begin w_alu_op = ALU_ADD;  w_gpr = 1'b1; w_imm = {{16{w_imm16[15]}}, w_imm16}; end
                6'h0A: begin w_alu_op = ALU_SLT;  w_gpr = 1'b1; w_imm = {{16{w_imm16[15]}}, w_imm16}; end
                6'h0B: begin w_alu_op = ALU_SLTU; w_gpr = 1'b1; w_imm = {{16{w_imm16[15]}}, w_imm16}; end
                6'h0C: begin w_alu_op = ALU_AND;  w_gpr = 1'b1; w_imm = {16'h0, w_imm16}; end
                6'h0D: begin w_alu_op = ALU_OR;   w_gpr = 1'b1; w_imm = {16'h0, w_imm16}; end
                6'h0E: begin w_alu_op = ALU_XOR;  w_gpr = 1'b1; w_imm = {16'h0, w_imm16}; end
                6'h0F: begin w_alu_op = ALU_LUI;  w_gpr = 1'b1; w_imm = {w_imm16, 16'h0}; end
                6'h23: begin
                    w_alu_op   = ALU_ADD;
                    w_gpr      = 1'b1;
                    w_mem_read = 1'b1;
                    w_imm      = {{16{w_imm16[15]}}, w_imm16};
                end
                6'h2B: begin
                    w_alu_op    = ALU_ADD;
                    w_mem_write = 1'b1;
                    w_imm       = {{16{w_imm16[15]}}, w_imm16};
                end
                default: w_legal = 1'b0;
            endcase
        end
    end

    assign w_dest = w_gpr ? ((w_opcode == 6'h00) ? in_instr[15:11] : in_instr[20:16]) : 5'd0;

    // Unsupported encodings collapse to a bundle that execute can safely ignore.
    always_comb begin
        w_dec            = '0;
        w_dec.instr      = in_instr;
        w_dec.rs         = in_instr[25:21];
        w_dec.rt         = in_instr[20:16];
        w_dec.rd         = in_instr[15:11];
        w_dec.shamt      = in_instr[10:6];
        w_dec.alu_op     = ALU_NONE;
        w_dec.illegal    = 1'b1;
        if (w_legal) begin
            w_dec.imm        = w_imm;
            w_dec.alu_op     = w_alu_op;
            w_dec.dest       = w_dest;
            w_dec.reg_write  = w_gpr && (w_dest != 5'd0);
            w_dec.mem_read   = w_mem_read;
            w_dec.mem_write  = w_mem_write;
            w_dec.hilo_write = w_hilo;
            w_dec.syscall    = w_sys;
            w_dec.illegal    = 1'b0;
        end
    end

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;

    // in_ready only tracks skid occupancy, so it never depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= C_RESET_BUNDLE;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else if (r_skid_valid) begin
            if (w_consume) begin
                r_out        <= r_skid;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end
        end else begin
            r_in_ready <= 1'b1;
            if (w_accept) begin
                if (!r_out_valid || out_ready) begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_skid       <= w_dec;
                    r_skid_valid <= 1'b1;
                    r_in_ready   <= 1'b0;
                end
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_count <= '0;
        end else if (w_accept && w_dec.illegal && (r_ill_count != '1)) begin
            r_ill_count <= r_ill_count + ILL_CNT_W'(1);
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign out_instr      = r_out.instr;
    assign out_rs         = r_out.rs;
    assign out_rt         = r_out.rt;
    assign out_rd         = r_out.rd;
    assign out_shamt      = r_out.shamt;
    assign out_imm        = r_out.imm;
    assign out_alu_op     = r_out.alu_op;
    assign out_dest       = r_out.dest;
    assign out_reg_write  = r_out.reg_write;
    assign out_mem_read   = r_out.mem_read;
    assign out_mem_write  = r_out.mem_write;
    assign out_hilo_write = r_out.hilo_write;
    assign out_syscall    = r_out.syscall;
    assign out_illegal    = r_out.illegal;
    assign ill_count      = r_ill_count;

endmodule
